// File: rtl/cp0_timer_ctrl_pkg.sv
// Shared CP0 constants: register numbers, exception codes and SR/Cause bit positions.
package cp0_timer_ctrl_pkg;
    localparam logic [4:0] RegBadVAddr = 5'd8;
    localparam logic [4:0] RegCount    = 5'd9;
    localparam logic [4:0] RegCompare  = 5'd11;
    localparam logic [4:0] RegSR       = 5'd12;
    localparam logic [4:0] RegCause    = 5'd13;
    localparam logic [4:0] RegEPC      = 5'd14;
    localparam logic [4:0] RegPrID     = 5'd15;

    localparam logic [4:0] ExcInt  = 5'd0;
    localparam logic [4:0] ExcAdEL = 5'd4;
    localparam logic [4:0] ExcAdES = 5'd5;
    localparam logic [4:0] ExcRI   = 5'd10;
    localparam logic [4:0] ExcOv   = 5'd12;

    localparam int unsigned SrIE       = 0;
    localparam int unsigned SrEXL      = 1;
    localparam int unsigned SrImLo     = 10;
    localparam int unsigned CauseBD    = 31;
    localparam int unsigned CauseTI    = 30;
    localparam int unsigned CauseIpLo  = 10;
    localparam int unsigned CauseExcLo = 2;
endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaler, free-running Count, Compare and the sticky TI flag.
module cp0_timer #(
    parameter int unsigned COUNT_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_count_we,
    input  logic        i_cmp_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);
    localparam logic [7:0] PRESC_MAX = 8'(COUNT_DIV - 1);

    logic [7:0]  r_presc;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    logic        w_tick;
    logic [31:0] w_count_inc;

    assign w_tick      = (r_presc == PRESC_MAX);
    assign w_count_inc = r_count + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            if (i_count_we) begin
                r_count <= i_wdata;
                r_presc <= '0;
            end else if (w_tick) begin
                r_count <= w_count_inc;
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 8'd1;
            end
            if (i_cmp_we)
                r_compare <= i_wdata;
            // TI only fires on an increment landing on Compare, never on a load.
            if (i_cmp_we)
                r_ti <= 1'b0;
            else if (!i_count_we && w_tick && (w_count_inc == r_compare))
                r_ti <= 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;
endmodule

// File: rtl/cp0_timer_ctrl.sv
// MIPS CP0 beside the M stage: SR/Cause/EPC/PrID/BadVAddr, Count/Compare timer,
// interrupt/exception arbitration and the eret return address.
module cp0_timer_ctrl
    import cp0_timer_ctrl_pkg::*;
#(
    parameter int unsigned N_HWINT   = 6,
    parameter logic [31:0] PRID_VAL  = 32'h4B46_0002,
    parameter int unsigned COUNT_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         A1,
    input  logic [4:0]         A2,
    input  logic [31:0]        DIn,
    input  logic               We,
    input  logic [31:0]        PC,
    input  logic               ExcInBd,
    input  logic [4:0]         ExcCode,
    input  logic [31:0]        BadVAddrIn,
    input  logic [N_HWINT-1:0] HWInt,
    input  logic               EXLClr,
    output logic               Req,
    output logic [31:0]        EPCOut,
    output logic [31:0]        DOut
);
    logic [31:0] r_sr;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [5:0]  r_ip;

    logic [5:0]  w_hw;
    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic        w_exl;
    logic        w_int_req;
    logic        w_exc_req;
    logic        w_wr_ok;
    logic        w_addr_exc;
    logic [31:0] w_epc_entry;
    logic [1:0]  w_unused;

    always_comb begin
        w_hw = '0;
        w_hw[N_HWINT-1:0] = HWInt;
    end

    assign w_exl       = r_sr[SrEXL];
    assign w_int_req   = (|(r_ip & r_sr[SrImLo +: 6])) & r_sr[SrIE] & ~w_exl;
    assign w_exc_req   = (ExcCode != ExcInt) & ~w_exl;
    assign Req         = w_int_req | w_exc_req;
    assign w_wr_ok     = We & ~EXLClr & ~Req;
    assign w_addr_exc  = (ExcCode == ExcAdEL) || (ExcCode == ExcAdES);
    assign w_epc_entry = ExcInBd ? {PC[31:2] - 30'd1, 2'b00} : {PC[31:2], 2'b00};
    assign w_unused    = PC[1:0];

    cp0_timer #(
        .COUNT_DIV(COUNT_DIV)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_count_we(w_wr_ok && (A2 == RegCount)),
        .i_cmp_we  (w_wr_ok && (A2 == RegCompare)),
        .i_wdata   (DIn),
        .o_count   (w_count),
        .o_compare (w_compare),
        .o_ti      (w_ti)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr       <= '0;
            r_epc      <= '0;
            r_badvaddr <= '0;
            r_bd       <= 1'b0;
            r_exccode  <= '0;
            r_ip       <= '0;
        end else begin
            r_ip <= {w_hw[5] | w_ti, w_hw[4:0]};
            if (EXLClr) begin
                r_sr[SrEXL] <= 1'b0;
            end else if (Req) begin
                r_sr[SrEXL] <= 1'b1;
                r_exccode   <= w_int_req ? ExcInt : ExcCode;
                r_bd        <= ExcInBd;
                r_epc       <= w_epc_entry;
                if (!w_int_req && w_addr_exc)
                    r_badvaddr <= BadVAddrIn;
            end else if (We) begin
                if (A2 == RegSR)
                    r_sr <= DIn;
                else if (A2 == RegEPC)
                    r_epc <= {DIn[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        DOut = '0;
        case (A1)
            RegBadVAddr: DOut = r_badvaddr;
            RegCount:    DOut = w_count;
            RegCompare:  DOut = w_compare;
            RegSR:       DOut = r_sr;
            RegCause:    DOut = {r_bd, w_ti, 14'b0, r_ip, 3'b0, r_exccode, 2'b00};
            RegEPC:      DOut = r_epc;
            RegPrID:     DOut = PRID_VAL;
            default:     DOut = '0;
        endcase
    end

    assign EPCOut = r_epc;
endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Scoreboard bench for cp0_timer_ctrl: main instance with COUNT_DIV=1, timer instance with COUNT_DIV=2.
module tb_cp0_timer_ctrl;
    localparam logic [31:0] PRID = 32'h4B46_0002;
    localparam logic [4:0] R_BADV = 5'd8, R_CNT = 5'd9, R_CMP = 5'd11, R_SR = 5'd12,
                           R_CAUSE = 5'd13, R_EPC = 5'd14, R_PRID = 5'd15;

    logic        clk, rst, We, ExcInBd, EXLClr;
    logic [4:0]  A1, A2, ExcCode;
    logic [31:0] DIn, PC, BadVAddrIn;
    logic [5:0]  HWInt;
    logic        Req, Req2;
    logic [31:0] EPCOut, EPCOut2, DOut, DOut2;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] obs[$];
    int          n_run, n_fail;

    cp0_timer_ctrl #(.N_HWINT(6), .PRID_VAL(PRID), .COUNT_DIV(1)) dut (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .DIn(DIn), .We(We), .PC(PC),
        .ExcInBd(ExcInBd), .ExcCode(ExcCode), .BadVAddrIn(BadVAddrIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .Req(Req), .EPCOut(EPCOut), .DOut(DOut)
    );

    cp0_timer_ctrl #(.N_HWINT(6), .PRID_VAL(PRID), .COUNT_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .DIn(DIn), .We(We), .PC(PC),
        .ExcInBd(ExcInBd), .ExcCode(ExcCode), .BadVAddrIn(BadVAddrIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .Req(Req2), .EPCOut(EPCOut2), .DOut(DOut2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string n, input logic [31:0] v);
        sb.push_back('{name: n, val: v});
    endtask

    task automatic rd(input logic [4:0] a);
        A1 = a;
        #1;
        obs.push_back(DOut);
    endtask

    task automatic rd2(input logic [4:0] a);
        A1 = a;
        #1;
        obs.push_back(DOut2);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        A2 = a; DIn = d; We = 1'b1;
        tick();
        We = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e; logic [31:0] o;
        rst = 1'b1;
        #1;
        push_exp("badvaddr", 32'h0);  rd(R_BADV);
        push_exp("count", 32'h0);     rd(R_CNT);
        push_exp("compare", 32'h0);   rd(R_CMP);
        push_exp("sr", 32'h0);        rd(R_SR);
        push_exp("cause", 32'h0);     rd(R_CAUSE);
        push_exp("epc", 32'h0);       rd(R_EPC);
        push_exp("prid", PRID);       rd(R_PRID);
        push_exp("unmapped", 32'h0);  rd(5'd3);
        push_exp("req", 32'h0);       obs.push_back({31'b0, Req});
        push_exp("epcout", 32'h0);    obs.push_back(EPCOut);
        tick();
        rst = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : 32'hxxxx_xxxx;
            n_run++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL reset/%s: got %h expected %h", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_exception(input logic bd);
        exp_t e; logic [31:0] o;
        reset_dut();
        wr(R_SR, 32'h0000_0401);
        ExcCode = 5'd12; PC = 32'h0000_3010; ExcInBd = bd;
        #1;
        push_exp("req_same_cycle", 32'h1); obs.push_back({31'b0, Req});
        tick();
        push_exp("req_held", 32'h0);       obs.push_back({31'b0, Req});
        push_exp("epc", bd ? 32'h0000_300C : 32'h0000_3010); rd(R_EPC);
        push_exp("epcout", bd ? 32'h0000_300C : 32'h0000_3010); obs.push_back(EPCOut);
        push_exp("cause", bd ? 32'h8000_0030 : 32'h0000_0030); rd(R_CAUSE);
        push_exp("sr_exl", 32'h0000_0403); rd(R_SR);
        ExcCode = 5'd0; ExcInBd = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : 32'hxxxx_xxxx;
            n_run++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL exception(bd=%0d)/%s: got %h expected %h", bd, e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_badvaddr();
        exp_t e; logic [31:0] o;
        reset_dut();
        ExcCode = 5'd4; BadVAddrIn = 32'h1234_5679; PC = 32'h0000_5000;
        tick();
        ExcCode = 5'd0;
        push_exp("adel_badv", 32'h1234_5679); rd(R_BADV);
        push_exp("adel_cause", 32'h0000_0010); rd(R_CAUSE);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        ExcCode = 5'd10; BadVAddrIn = 32'hCAFE_0000;
        tick();
        ExcCode = 5'd0;
        push_exp("ri_badv_kept", 32'h1234_5679); rd(R_BADV);
        push_exp("ri_cause", 32'h0000_0028); rd(R_CAUSE);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : 32'hxxxx_xxxx;
            n_run++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL badvaddr/%s: got %h expected %h", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_simultaneous();
        exp_t e; logic [31:0] o;
        reset_dut();
        wr(R_SR, 32'h0000_0401);
        HWInt = 6'b000001;
        tick();
        ExcCode = 5'd4; BadVAddrIn = 32'hDEAD_0000; PC = 32'h0000_4000;
        #1;
        push_exp("req", 32'h1); obs.push_back({31'b0, Req});
        tick();
        push_exp("cause_int", 32'h0000_0400); rd(R_CAUSE);
        push_exp("badv_unchanged", 32'h0); rd(R_BADV);
        push_exp("sr_exl", 32'h0000_0403); rd(R_SR);
        push_exp("req_in_exl", 32'h0); obs.push_back({31'b0, Req});
        ExcCode = 5'd0; EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        push_exp("sr_after_eret", 32'h0000_0401); rd(R_SR);
        push_exp("req_reassert", 32'h1); obs.push_back({31'b0, Req});
        HWInt = 6'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : 32'hxxxx_xxxx;
            n_run++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL simultaneous/%s: got %h expected %h", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_timer();
        exp_t e; logic [31:0] o;
        reset_dut();
        wr(R_SR, 32'h0000_8001);
        wr(R_CMP, 32'd3);
        wr(R_CNT, 32'd0);
        repeat (5) tick();
        push_exp("count_5cyc", 32'd2); rd2(R_CNT);
        push_exp("cause_5cyc", 32'h0); rd2(R_CAUSE);
        tick();
        push_exp("count_6cyc", 32'd3); rd2(R_CNT);
        push_exp("cause_ti", 32'h4000_0000); rd2(R_CAUSE);
        push_exp("req_before_ip7", 32'h0); obs.push_back({31'b0, Req2});
        tick();
        push_exp("req_timer", 32'h1); obs.push_back({31'b0, Req2});
        push_exp("cause_ip7", 32'h4000_8000); rd2(R_CAUSE);
        tick();
        push_exp("sr_entry", 32'h0000_8003); rd2(R_SR);
        wr(R_CMP, 32'd100);
        push_exp("compare_new", 32'd100); rd2(R_CMP);
        push_exp("cause_ti_clr", 32'h0000_8000); rd2(R_CAUSE);
        EXLClr = 1'b1;
        tick();
        EXLClr = 1'b0;
        push_exp("cause_idle", 32'h0); rd2(R_CAUSE);
        push_exp("req_dropped", 32'h0); obs.push_back({31'b0, Req2});
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : 32'hxxxx_xxxx;
            n_run++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL timer/%s: got %h expected %h", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_wrap_priority();
        exp_t e; logic [31:0] o;
        reset_dut();
        wr(R_CNT, 32'hFFFF_FFFF);
        push_exp("count_loaded", 32'hFFFF_FFFF); rd(R_CNT);
        tick();
        push_exp("count_wrapped", 32'h0); rd(R_CNT);
        push_exp("ti_on_wrap", 32'h4000_0000); rd(R_CAUSE);
        ExcCode = 5'd12; PC = 32'h0000_6000;
        A2 = R_SR; DIn = 32'h0000_FC01; We = 1'b1;
        tick();
        We = 1'b0; ExcCode = 5'd0;
        push_exp("sr_write_dropped", 32'h0000_0002); rd(R_SR);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : 32'hxxxx_xxxx;
            n_run++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL wrap_priority/%s: got %h expected %h", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_mtc0();
        exp_t e; logic [31:0] o;
        reset_dut();
        wr(R_EPC, 32'h1234_5677);
        push_exp("epc_aligned", 32'h1234_5674); rd(R_EPC);
        push_exp("epcout_aligned", 32'h1234_5674); obs.push_back(EPCOut);
        wr(5'd3, 32'h0000_FFFF);
        push_exp("unmapped_rd", 32'h0); rd(5'd3);
        wr(R_CAUSE, 32'hFFFF_FFFF);
        push_exp("cause_ro", 32'h0); rd(R_CAUSE);
        wr(R_PRID, 32'h0);
        push_exp("prid_ro", PRID); rd(R_PRID);
        wr(R_CMP, 32'd5);
        wr(R_CNT, 32'd5);
        push_exp("count_load_eq", 32'd5); rd(R_CNT);
        push_exp("no_ti_on_load", 32'h0); rd(R_CAUSE);
        A1 = R_SR; A2 = R_SR; DIn = 32'h0000_0055; We = 1'b1;
        #1;
        push_exp("read_old_sr", 32'h0); obs.push_back(DOut);
        tick();
        We = 1'b0;
        push_exp("sr_written", 32'h0000_0055); rd(R_SR);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : 32'hxxxx_xxxx;
            n_run++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL mtc0/%s: got %h expected %h", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    task automatic test_async_reset();
        exp_t e; logic [31:0] o;
        reset_dut();
        wr(R_SR, 32'h0000_8001);
        wr(R_CNT, 32'hFFFF_FFFF);
        tick();
        tick();
        push_exp("req_pre", 32'h1); obs.push_back({31'b0, Req});
        #2;
        rst = 1'b1;
        #1;
        push_exp("req_async", 32'h0); obs.push_back({31'b0, Req});
        push_exp("cause_async", 32'h0); rd(R_CAUSE);
        push_exp("sr_async", 32'h0); rd(R_SR);
        push_exp("count_async", 32'h0); rd(R_CNT);
        push_exp("prid_async", PRID); rd(R_PRID);
        tick();
        rst = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : 32'hxxxx_xxxx;
            n_run++;
            if (o !== e.val) begin
                n_fail++;
                $display("FAIL async_reset/%s: got %h expected %h", e.name, o, e.val);
            end
        end
        obs.delete();
    endtask

    initial begin
        n_run = 0; n_fail = 0;
        rst = 1'b1; We = 1'b0; ExcInBd = 1'b0; EXLClr = 1'b0;
        A1 = '0; A2 = '0; ExcCode = '0; DIn = '0; PC = '0; BadVAddrIn = '0; HWInt = '0;
        test_reset();
        test_exception(1'b0);
        test_exception(1'b1);
        test_badvaddr();
        test_simultaneous();
        test_timer();
        test_wrap_priority();
        test_mtc0();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
